// File: rtl/multi_player_controller.sv
// N-player input front end: per-pin sync + debounce, SOCD cleaning, attack-press pulse.
// Define MPC_COMBO_EN to build the per-player special-move detector; otherwise special is tied 0.
module multi_player_controller #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int COMBO_WINDOW    = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PLAYERS-1:0]   left_l,
    input  logic [NUM_PLAYERS-1:0]   right_l,
    input  logic [NUM_PLAYERS-1:0]   up_l,
    input  logic [NUM_PLAYERS-1:0]   down_l,
    input  logic [NUM_PLAYERS-1:0]   attack,
    input  logic [NUM_PLAYERS-1:0]   shield,
    output logic [7*NUM_PLAYERS-1:0] controller_inputs,
    output logic [NUM_PLAYERS-1:0]   special
);
    localparam int              NPINS     = 6 * NUM_PLAYERS;
    localparam longint          CNT_LIMIT = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || COMBO_WINDOW < 1 ||
        longint'(DEBOUNCE_CYCLES) >= CNT_LIMIT || longint'(COMBO_WINDOW) >= CNT_LIMIT) begin : g_bad_params
        $error("multi_player_controller: DEBOUNCE_CYCLES/COMBO_WINDOW must be in 1 .. 2**CNT_W-1");
    end

    logic [NPINS-1:0]         pressed;
    logic [NPINS-1:0]         sync1_q, sync1_d;
    logic [NPINS-1:0]         sync2_q, sync2_d;
    logic [NPINS-1:0]         stable_q, stable_d;
    logic [CNT_W-1:0]         db_cnt_q [NPINS];
    logic [CNT_W-1:0]         db_cnt_d [NPINS];
    logic [7*NUM_PLAYERS-1:0] ci_q, ci_d;

    // Pin order within a player: left, right, up, down, attack, shield (all active-high pressed).
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pins
        assign pressed[6*g+0] = ~left_l[g];
        assign pressed[6*g+1] = ~right_l[g];
        assign pressed[6*g+2] = ~up_l[g];
        assign pressed[6*g+3] = ~down_l[g];
        assign pressed[6*g+4] = attack[g];
        assign pressed[6*g+5] = shield[g];
    end

    assign sync1_d = pressed;
    assign sync2_d = sync1_q;

    always_comb begin
        stable_d = stable_q;
        for (int j = 0; j < NPINS; j++) begin
            db_cnt_d[j] = '0;
            if (sync2_q[j] != stable_q[j]) begin
                if (db_cnt_q[j] == DB_LAST) begin
                    stable_d[j] = ~stable_q[j];
                end else begin
                    db_cnt_d[j] = db_cnt_q[j] + CNT_W'(1);
                end
            end
        end
    end

    // Opposing directions cancel; ci_q[7p+4] doubles as last cycle's stable attack for the edge detect.
    always_comb begin
        ci_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            ci_d[7*p+0] = stable_q[6*p+0] & ~stable_q[6*p+1];
            ci_d[7*p+1] = stable_q[6*p+1] & ~stable_q[6*p+0];
            ci_d[7*p+2] = stable_q[6*p+2] & ~stable_q[6*p+3];
            ci_d[7*p+3] = stable_q[6*p+3] & ~stable_q[6*p+2];
            ci_d[7*p+4] = stable_q[6*p+4];
            ci_d[7*p+5] = stable_q[6*p+5];
            ci_d[7*p+6] = stable_q[6*p+4] & ~ci_q[7*p+4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            ci_q     <= '0;
            for (int j = 0; j < NPINS; j++) begin
                db_cnt_q[j] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            ci_q     <= ci_d;
            for (int j = 0; j < NPINS; j++) begin
                db_cnt_q[j] <= db_cnt_d[j];
            end
        end
    end

    assign controller_inputs = ci_q;

`ifdef MPC_COMBO_EN
    // state   | meaning
    // ST_IDLE | waiting for a down press
    // ST_DOWN | down seen, waiting for right
    // ST_FWD  | down-right seen, waiting for attack press
    // ST_FIRE | special pulse cycle, then back to idle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DOWN = 2'd1;
    localparam logic [1:0] ST_FWD  = 2'd2;
    localparam logic [1:0] ST_FIRE = 2'd3;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(COMBO_WINDOW - 1);

    logic [1:0]               state_q [NUM_PLAYERS];
    logic [1:0]               state_d [NUM_PLAYERS];
    logic [CNT_W-1:0]         win_q   [NUM_PLAYERS];
    logic [CNT_W-1:0]         win_d   [NUM_PLAYERS];
    logic [4*NUM_PLAYERS-1:0] dir_prev_q, dir_prev_d;
    logic [NUM_PLAYERS-1:0]   special_q, special_d;
    logic [3:0]               rise    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]   atk_step;

    // Steps come from the registered word, so special lands the cycle after the attack pulse.
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_steps
        assign rise[g]              = ci_q[7*g +: 4] & ~dir_prev_q[4*g +: 4];
        assign atk_step[g]          = ci_q[7*g+6];
        assign dir_prev_d[4*g +: 4] = ci_q[7*g +: 4];
    end

    always_comb begin
        special_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            state_d[p] = state_q[p];
            win_d[p]   = win_q[p];
            case (state_q[p])
                ST_IDLE: begin
                    if (rise[p][3]) begin
                        state_d[p] = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    win_d[p] = win_q[p] + CNT_W'(1);
                    if (rise[p][1]) begin
                        state_d[p] = ST_FWD;
                        win_d[p]   = '0;
                    end else if ((|rise[p]) || win_q[p] == WIN_LAST) begin
                        state_d[p] = ST_IDLE;
                        win_d[p]   = '0;
                    end
                end
                ST_FWD: begin
                    win_d[p] = win_q[p] + CNT_W'(1);
                    if (atk_step[p]) begin
                        state_d[p]   = ST_FIRE;
                        win_d[p]     = '0;
                        special_d[p] = 1'b1;
                    end else if (rise[p][3]) begin
                        state_d[p] = ST_DOWN;
                        win_d[p]   = '0;
                    end else if ((|rise[p]) || win_q[p] == WIN_LAST) begin
                        state_d[p] = ST_IDLE;
                        win_d[p]   = '0;
                    end
                end
                default: begin
                    state_d[p] = ST_IDLE;
                    win_d[p]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_prev_q <= '0;
            special_q  <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state_q[p] <= ST_IDLE;
                win_q[p]   <= '0;
            end
        end else begin
            dir_prev_q <= dir_prev_d;
            special_q  <= special_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state_q[p] <= state_d[p];
                win_q[p]   <= win_d[p];
            end
        end
    end

    assign special = special_q;
`else
    assign special = '0;
`endif

endmodule

// File: doc/multi_player_controller.md
# multi_player_controller

Parametrised N-player input front end that replaces per-player controller instances in the game top. Each player's six raw button pins are synchronised, debounced and SOCD-cleaned, and each player gets a 7-bit packed input word plus an attack-press pulse. An optional per-player combo detector recognises a special move. Output feeds game logic in the same clock domain.

## Interface
- NUM_PLAYERS, 2, number of independent player channels (≥1)
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level (10 ms @ 100 MHz)
- COMBO_WINDOW, 25000000, max cycles between successive combo steps (250 ms)
- CNT_W, 25, counter width; DEBOUNCE_CYCLES and COMBO_WINDOW must be < 2**CNT_W
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- left_l, right_l, up_l, down_l  in  NUM_PLAYERS each  active-low direction pins, bit p = player p
- attack, shield  in  NUM_PLAYERS each  active-high button pins
- controller_inputs  out  7*NUM_PLAYERS  player p in bits [7p+6:7p]: 0 left, 1 right, 2 up, 3 down, 4 attack held, 5 shield held, 6 attack_press (1-cycle pulse)
- special  out  NUM_PLAYERS  1-cycle pulse on combo completion (tied 0 when combo excluded)

## Operation
- All inputs are converted internally to active-high "pressed" before synchronisation.
- Per pin: 2-flop synchroniser -> debouncer -> stable level.
- Debouncer: counter cleared while synced level equals stable level; otherwise increments each cycle. When the counter would reach DEBOUNCE_CYCLES, the stable level toggles and the counter clears. A glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
- SOCD cleaning on stable levels:
  - left and right both pressed -> both output 0.
  - up and down both pressed -> both output 0.
  - Attack and shield are not cleaned; both may be 1.
- attack_press = stable attack rising edge; high for exactly one cycle per accepted press.
- Players are fully independent: no shared counters and no cross-player interaction.
- Combo FSM per player (when compiled in). Steps are rising edges of cleaned directions or of attack_press. Window counter clears on every transition.
  - IDLE: down press -> S_DOWN.
  - S_DOWN: right press -> S_FWD. Other direction press -> IDLE. Window expiry (COMBO_WINDOW cycles without a step) -> IDLE.
  - S_FWD: attack_press -> FIRE. Down press -> S_DOWN. Other direction press -> IDLE. Window expiry -> IDLE.
  - FIRE: special=1 for one cycle -> IDLE unconditionally.
  - When a step and expiry occur in the same cycle, the step wins.

## Timing
- Reset: synchroniser flops and stable levels = released; all counters 0; FSMs in IDLE; controller_inputs = 0; special = 0.
- rst asserted mid-operation clears everything immediately (async). A press held through reset must re-qualify for the full DEBOUNCE_CYCLES.
- Latency, pin edge to controller_inputs: 2 sync cycles + DEBOUNCE_CYCLES + 1 output register cycle. Release latency is identical.
- attack_press is aligned with the cycle in which bit 4 first reads 1.
- special is asserted the cycle after attack_press is seen in S_FWD. It is never concurrent with the attack_press that fired it.
- All outputs are registered; there are no combinational paths from pins to outputs.

## Configuration
- MPC_COMBO_EN defined: combo FSMs and window counters are instantiated; special behaves as above.
- Not defined: no FSM or counter logic is generated; special is constant 0; all other behaviour is unchanged.

## Test plan
Use NUM_PLAYERS=2, DEBOUNCE_CYCLES=4, COMBO_WINDOW=10.
- Bounce: drive p0 left_l low for 3 cycles then high -> bit 0 stays 0. Drive it low for 10 cycles -> bit 0 = 1 exactly 7 cycles after the falling edge.
- SOCD: p1 left_l and right_l both low (stable) -> bits 7 and 8 = 0. Release right_l -> bit 7 = 1 after the latency.
- Attack press: p0 attack held high for 20 cycles -> bit 4 = 1 for the duration; bit 6 pulses exactly once. Then p1 shield high -> bit 12 = 1 and p0 word is unchanged.
- Combo: p0 down, right, attack, each step 5 cycles after the prior debounced edge -> special[0] = 1 for one cycle. With an 11-cycle gap before attack -> special[0] stays 0. Without MPC_COMBO_EN -> special = 0 always.
- Reset mid-operation: assert rst while p0 down is held and the FSM is in S_DOWN -> outputs are 0 at once. After rst falls, bit 3 returns only after the full latency, and the FSM restarts from IDLE.
